// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display reader.
// Holds the active-low segment code table (seg[6]=a .. seg[0]=g),
// the reader FSM state type and the output record layout.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Wide enough for the largest supported digit count (8).
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EMIT
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       val;
        logic             err;
        logic             blank;
    } record_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational seven-segment pattern to BCD decoder.
// Ports:
//   seg   in  7  active-low segment pattern, seg[6]=a .. seg[0]=g
//   val   out 4  decoded digit, 4'hF when blank or undecodable
//   err   out 1  pattern is not a known digit and not blank
//   blank out 1  all segments off
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       err,
    output logic       blank
);

    always_comb begin
        val   = 4'hF;
        err   = 1'b0;
        blank = 1'b0;
        case (seg)
            SEG_0:     val = 4'd0;
            SEG_1:     val = 4'd1;
            SEG_2:     val = 4'd2;
            SEG_3:     val = 4'd3;
            SEG_4:     val = 4'd4;
            SEG_5:     val = 4'd5;
            SEG_6:     val = 4'd6;
            SEG_7:     val = 4'd7;
            SEG_8:     val = 4'd8;
            SEG_9:     val = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Multiplexed seven-segment display reader.
// Synchronizes the segment and digit-enable pins, waits for the combined
// pattern to hold for STABLE_CYC samples, decodes it and offers a
// {idx, val, err, blank} record on a valid/ready port with a one-entry buffer.
// Optional build macro: SEVENSEG_RD_CHANGE_ONLY_EN -- only emit a digit when
// its decoded content differs from the last record loaded for that digit.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   seg[6:0]        active-low segment pins (asynchronous)
//   dig[NDIG-1:0]   active-high digit enables (asynchronous)
//   out_valid/out_ready  record handshake
//   out_idx, out_val, out_err, out_blank  record fields
//   ovf             sticky: a record was dropped because the buffer was full
//
// state  | meaning
// IDLE   | pattern already handled, waiting for a sample change
// SETTLE | counting identical samples of a new pattern
// EMIT   | one cycle offering the settled record to the output buffer
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 16,
    localparam int IW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      seg,
    input  logic [NDIG-1:0] dig,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_idx,
    output logic [3:0]      out_val,
    output logic            out_err,
    output logic            out_blank,
    output logic            ovf
);

    localparam int          SW       = NDIG + 7;
    localparam logic [15:0] STAB_SAT = 16'(STABLE_CYC);
    localparam logic [15:0] STAB_END = 16'(STABLE_CYC - 1);

    logic [6:0]      seg_meta, s_seg;
    logic [NDIG-1:0] dig_meta, s_dig;
    logic [SW-1:0]   sample, prev_sample;
    logic            change;
    logic [15:0]     stab, stab_next;
    state_t          state, state_next;
    logic [6:0]      held_seg;
    logic [NDIG-1:0] held_dig;
    logic            held_one_hot;
    logic [IW-1:0]   held_idx;
    logic [3:0]      dec_val;
    logic            dec_err, dec_blank;
    logic            suppress;
    logic            load;
    record_t         rec_q;
    logic            unused_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= SEG_BLANK;
            s_seg    <= SEG_BLANK;
            dig_meta <= '0;
            s_dig    <= '0;
        end else begin
            seg_meta <= seg;
            s_seg    <= seg_meta;
            dig_meta <= dig;
            s_dig    <= dig_meta;
        end
    end

    assign sample = {s_dig, s_seg};
    assign change = (sample != prev_sample);

    always_comb begin
        if (change)
            stab_next = '0;
        else if (stab == STAB_SAT)
            stab_next = stab;
        else
            stab_next = stab + 16'd1;
    end

    // Decode from the previous sample: it equals the current one whenever a
    // decision is taken in SETTLE, and in EMIT it still holds the settled
    // pattern even if the pins moved during that cycle.
    assign held_seg     = prev_sample[6:0];
    assign held_dig     = prev_sample[SW-1:7];
    assign held_one_hot = (held_dig != '0) && ((held_dig & (held_dig - NDIG'(1))) == '0);

    always_comb begin
        held_idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (held_dig[i]) held_idx = IW'(i);
    end

    sevenseg_decode u_decode (
        .seg   (held_seg),
        .val   (dec_val),
        .err   (dec_err),
        .blank (dec_blank)
    );

`ifdef SEVENSEG_RD_CHANGE_ONLY_EN
    logic [5:0] shadow [NDIG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++)
                shadow[i] <= 6'b0000_01;
        end else if (load) begin
            shadow[held_idx] <= {dec_val, dec_err, dec_blank};
        end
    end

    assign suppress = (shadow[held_idx] == {dec_val, dec_err, dec_blank});
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stab        <= '0;
            prev_sample <= {{NDIG{1'b0}}, SEG_BLANK};
        end else begin
            state       <= state_next;
            stab        <= stab_next;
            prev_sample <= sample;
        end
    end

    // A change while settling simply restarts the count. A change landing in
    // the EMIT cycle starts a new settle directly, otherwise it would be lost.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (change) state_next = SETTLE;
            end
            SETTLE: begin
                if (!change && stab_next == STAB_END)
                    state_next = (held_one_hot && !suppress) ? EMIT : IDLE;
            end
            EMIT: begin
                state_next = change ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign load = (state == EMIT) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rec_q     <= '0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                rec_q     <= {IDX_W'(held_idx), dec_val, dec_err, dec_blank};
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == EMIT && !load)
                ovf <= 1'b1;
        end
    end

    assign out_idx    = rec_q.idx[IW-1:0];
    assign out_val    = rec_q.val;
    assign out_err    = rec_q.err;
    assign out_blank  = rec_q.blank;
    assign unused_idx = ^rec_q.idx;

endmodule

// File: tb/tb_sevenseg_reader.sv
module tb_sevenseg_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 16;
`ifdef SEVENSEG_RD_CHANGE_ONLY_EN
    localparam bit CHANGE_ONLY = 1'b1;
`else
    localparam bit CHANGE_ONLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_ready = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [3:0] dig = 4'b0000;
    logic       out_valid, out_err, out_blank, ovf;
    logic [1:0] out_idx;
    logic [3:0] out_val;

    int tests = 0;
    int fails = 0;
    bit rnd_ready = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    logic [7:0] dut_log [$];
    logic [7:0] m_log [$];

    sevenseg_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig       (dig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_val   (out_val),
        .out_err   (out_err),
        .out_blank (out_blank),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {val, err, blank} straight from the code table
    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        for (int v = 0; v < 10; v++)
            if (s == seg_tbl[v]) return {4'(v), 2'b00};
        if (s == 7'h7F) return {4'hF, 2'b01};
        return {4'hF, 2'b10};
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] d);
        for (int i = 0; i < 4; i++)
            if (d[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Reference model in the pin domain: a pattern seen on STABLE_CYC
    // consecutive clock edges is offered to the buffer 3 edges later
    // (2 synchronizer edges + 1 load edge).
    logic       m_valid, m_ovf;
    logic [7:0] m_rec, p_rec;
    logic [10:0] pins_prev, cur;
    int         cnt, ecount, due;
    logic [5:0] m_shadow [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   = 1'b0;
            m_ovf     = 1'b0;
            m_rec     = '0;
            pins_prev = {4'b0000, 7'h7F};
            cnt       = 1;
            ecount    = 0;
            due       = -1;
            for (int i = 0; i < 4; i++) m_shadow[i] = 6'b000001;
        end else begin
            ecount++;
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_log.push_back(m_rec);
            end
            if (due == ecount) begin
                due = -1;
                if (!(CHANGE_ONLY && m_shadow[p_rec[7:6]] == p_rec[5:0])) begin
                    if (!m_valid) begin
                        m_valid = 1'b1;
                        m_rec   = p_rec;
                        m_shadow[p_rec[7:6]] = p_rec[5:0];
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            cur = {dig, seg};
            if (cur == pins_prev) begin
                if (cnt < 1000000) cnt++;
            end else begin
                cnt = 1;
            end
            pins_prev = cur;
            if (cnt == STABLE_CYC && $countones(dig) == 1) begin
                due   = ecount + 3;
                p_rec = {onehot_index(dig), ref_decode(seg)};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (m_valid && out_valid)
                chk("record", 32'({out_idx, out_val, out_err, out_blank}), 32'(m_rec));
            if (out_valid && out_ready)
                dut_log.push_back({out_idx, out_val, out_err, out_blank});
        end
    end

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        dig = d;
        seg = s;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic measure(input string name, input int exp_n);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 200);
        chk(name, 32'(n), 32'(exp_n));
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        dut_log.delete();
        m_log.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_val", 32'(out_val), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_blank", 32'(out_blank), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #1;
        rst_n = 1'b1;

        // single digit, latency from pin change
        dig = 4'b0010;
        seg = 7'b0000110;
        measure("latency", 19);
        hold(4'b0010, 7'b0000110, 5);
        chk("t1_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("t1_rec", 32'(dut_log[0]), 32'h4C);
        if (m_log.size() > 0) chk("t1_model_rec", 32'(m_log[0]), 32'h4C);

        // scan four digits
        clear_logs();
        hold(4'b0001, 7'b0000100, 40);
        hold(4'b0010, 7'b1001111, 40);
        hold(4'b0100, 7'b0000000, 40);
        hold(4'b1000, 7'b0000001, 40);
        chk("scan_count", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() == 4) begin
            chk("scan_0", 32'(dut_log[0]), 32'({2'd0, 4'd9, 2'b00}));
            chk("scan_1", 32'(dut_log[1]), 32'({2'd1, 4'd1, 2'b00}));
            chk("scan_2", 32'(dut_log[2]), 32'({2'd2, 4'd8, 2'b00}));
            chk("scan_3", 32'(dut_log[3]), 32'({2'd3, 4'd0, 2'b00}));
        end
        chk("scan_ovf", 32'(ovf), 32'd0);

        // two-hot dig, then undecodable pattern on one digit
        clear_logs();
        hold(4'b0011, 7'b1111110, 40);
        chk("twohot_none", 32'(dut_log.size()), 32'd0);
        hold(4'b0001, 7'b1111110, 40);
        chk("err_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("err_rec", 32'(dut_log[0]), 32'({2'd0, 4'hF, 2'b10}));

        // consumer stalled: first record held, second dropped
        clear_logs();
        out_ready = 1'b0;
        hold(4'b0010, 7'b0010010, 40);
        hold(4'b0100, 7'b0100100, 40);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_rec", 32'({out_idx, out_val}), 32'({2'd1, 4'd2}));
        chk("stall_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        hold(4'b0100, 7'b0100100, 10);
        chk("stall_xfers", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("stall_xfer_rec", 32'(dut_log[0]), 32'({2'd1, 4'd2, 2'b00}));

        // reset in the middle of settling
        clear_logs();
        hold(4'b1000, 7'b0001111, 8);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        hold(4'b1000, 7'b0001111, 40);
        chk("postrst_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("postrst_rec", 32'(dut_log[0]), 32'({2'd3, 4'd7, 2'b00}));

        // single-cycle glitch on seg[3] at clock 10 of settling
        clear_logs();
        hold(4'b0100, 7'b1001100, 10);
        hold(4'b0100, 7'b1000100, 1);
        dig = 4'b0100;
        seg = 7'b1001100;
        measure("glitch_latency", 19);
        hold(4'b0100, 7'b1001100, 10);
        chk("glitch_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("glitch_rec", 32'(dut_log[0]), 32'({2'd2, 4'd4, 2'b00}));

        // digit 0 alternating between 5 and blank, then 5 repeated across a glitch
        clear_logs();
        hold(4'b0001, 7'b0100100, 40);
        hold(4'b0001, 7'b1111111, 40);
        hold(4'b0001, 7'b0100100, 40);
        hold(4'b0001, 7'b0101100, 1);
        hold(4'b0001, 7'b0100100, 40);
`ifdef SEVENSEG_RD_CHANGE_ONLY_EN
        chk("chg_count", 32'(dut_log.size()), 32'd3);
`else
        chk("chg_count", 32'(dut_log.size()), 32'd4);
`endif
        if (dut_log.size() >= 3) begin
            chk("chg_rec0", 32'(dut_log[0]), 32'({2'd0, 4'd5, 2'b00}));
            chk("chg_rec1", 32'(dut_log[1]), 32'({2'd0, 4'hF, 2'b01}));
            chk("chg_rec2", 32'(dut_log[2]), 32'({2'd0, 4'd5, 2'b00}));
        end

        // randomized patterns, hold times and consumer back-pressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            logic [3:0] d;
            logic [6:0] s;
            int         v;
            if ($urandom_range(0, 4) != 0) d = 4'(1 << $urandom_range(0, 3));
            else d = 4'($urandom);
            v = int'($urandom_range(0, 13));
            if (v < 10) s = seg_tbl[v];
            else if (v == 10) s = 7'h7F;
            else s = 7'($urandom);
            hold(d, s, int'($urandom_range(1, 40)));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        hold(4'b0000, 7'h7F, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
